logicnet_lut_layer: RTL and testbench

//  Parametrised, pipelined LogicNets layer: N_NEURONS truth-table neurons, each FAN_IN*IN_BITS in / OUT_BITS out.

---
 rtl/logicnet_lut_layer.sv | 143 ++++++++++++++
 tb/tb_logicnet_lut_layer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logicnet_lut_layer.sv
// LogicNets truth-table layer: N_NEURONS runtime-writable LUT neurons behind a
// 2-stage valid/ready pipeline, with a config port that drains the pipe before writing.
module logicnet_lut_layer #(
  parameter  int N_NEURONS = 4,
  parameter  int FAN_IN    = 3,
  parameter  int IN_BITS   = 2,
  parameter  int OUT_BITS  = 2,
  localparam int ADDR_W    = FAN_IN * IN_BITS,
  localparam int DEPTH     = 2 ** ADDR_W,
  localparam int NID_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*ADDR_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [NID_W-1:0]              cfg_neuron,
  input  logic [ADDR_W-1:0]             cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          cfg_err,
  output logic                          busy
);

  typedef enum logic [1:0] {INIT, RUN, DRAIN, CFG} state_t;

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               initCnt_q, initCnt_d;
  logic                            s1Valid_q, s1Valid_d;
  logic [N_NEURONS*ADDR_W-1:0]     s1Data_q, s1Data_d;
  logic                            s2Valid_q, s2Valid_d;
  logic [N_NEURONS*OUT_BITS-1:0]   s2Data_q, s2Data_d;
  logic                            cfgErr_q, cfgErr_d;

  logic                            adv1, adv2;
  logic                            inReady, accept;
  logic                            cfgAccept, cfgInRange;
  logic [ADDR_W-1:0]               wAddr;
  logic [OUT_BITS-1:0]             wData;
  logic [N_NEURONS*OUT_BITS-1:0]   lutRead;

  assign adv2       = !s2Valid_q || out_ready;
  assign adv1       = !s1Valid_q || adv2;
  assign inReady    = (state_q == RUN) && !cfg_valid && adv1;
  assign accept     = in_valid && inReady;
  assign cfgAccept  = (state_q == CFG) && cfg_valid;
  assign cfgInRange = int'(cfg_neuron) < N_NEURONS;

  // INIT sweeps every table with zeros; CFG writes one entry of one neuron.
  assign wAddr = (state_q == INIT) ? initCnt_q : cfg_addr;
  assign wData = (state_q == INIT) ? '0 : cfg_data;

  for (genvar n = 0; n < N_NEURONS; n++) begin : gNeuron
    logic [OUT_BITS-1:0] lutMem [DEPTH];
    logic                we;

    assign we = (state_q == INIT) ||
                (cfgAccept && cfgInRange && (cfg_neuron == NID_W'(n)));

    always_ff @(posedge clk) begin
      if (we) lutMem[wAddr] <= wData;
    end

    assign lutRead[n*OUT_BITS +: OUT_BITS] = lutMem[s1Data_q[n*ADDR_W +: ADDR_W]];

    // Writes only ever happen with an empty pipeline, so no lookup sees a half-written table.
    assert property (@(posedge clk) disable iff (!rst_n)
                     we |-> (!s1Valid_q && !s2Valid_q));
  end

  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    case (state_q)
      INIT: begin
        initCnt_d = initCnt_q + 1'b1;
        if (initCnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (cfg_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (!s1Valid_q && !s2Valid_q) state_d = CFG;
      end
      CFG: begin
        if (!cfg_valid) state_d = RUN;
      end
      default: begin
        state_d   = INIT;
        initCnt_d = '0;
      end
    endcase
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Data_d  = s1Data_q;
    s2Valid_d = s2Valid_q;
    s2Data_d  = s2Data_q;
    cfgErr_d  = cfgAccept && !cfgInRange;
    if (adv1) s1Valid_d = accept;
    if (accept) s1Data_d = in_data;
    if (adv2) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) s2Data_d = lutRead;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      initCnt_q <= '0;
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
      cfgErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
      s1Valid_q <= s1Valid_d;
      s1Data_q  <= s1Data_d;
      s2Valid_q <= s2Valid_d;
      s2Data_q  <= s2Data_d;
      cfgErr_q  <= cfgErr_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
                   (s2Valid_q && !out_ready) |=> (s2Valid_q && $stable(s2Data_q)));

  assign in_ready  = inReady;
  assign out_valid = s2Valid_q;
  assign out_data  = s2Data_q;
  assign cfg_ready = (state_q == CFG);
  assign cfg_err   = cfgErr_q;
  assign busy      = (state_q != RUN);

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Directed bench for logicnet_lut_layer: a 4-neuron instance for the stream/config
// paths and a 3-neuron instance for the out-of-range config write.
module tb_logicnet_lut_layer;

  logic        clk;
  logic        rst_n;

  logic        inValid, inReady, outValid, outReady;
  logic [23:0] inData;
  logic [7:0]  outData;
  logic        cfgValid, cfgReady, cfgErr, busy;
  logic [1:0]  cfgNeuron;
  logic [5:0]  cfgAddr;
  logic [1:0]  cfgData;

  logic        bInValid, bInReady, bOutValid, bOutReady;
  logic [17:0] bInData;
  logic [5:0]  bOutData;
  logic        bCfgValid, bCfgReady, bCfgErr, bBusy;
  logic [1:0]  bCfgNeuron;
  logic [5:0]  bCfgAddr;
  logic [1:0]  bCfgData;

  int          checks;
  int          errors;
  logic [7:0]  rxQ [$];
  logic [23:0] beats [6];
  logic [7:0]  beatExp [6];

  logicnet_lut_layer #(.N_NEURONS(4)) dutA (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .cfg_valid(cfgValid), .cfg_ready(cfgReady), .cfg_neuron(cfgNeuron),
    .cfg_addr(cfgAddr), .cfg_data(cfgData), .cfg_err(cfgErr), .busy(busy)
  );

  logicnet_lut_layer #(.N_NEURONS(3)) dutB (
    .clk(clk), .rst_n(rst_n),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
    .cfg_valid(bCfgValid), .cfg_ready(bCfgReady), .cfg_neuron(bCfgNeuron),
    .cfg_addr(bCfgAddr), .cfg_data(bCfgData), .cfg_err(bCfgErr), .busy(bBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every output handshake of the 4-neuron layer, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) rxQ.push_back(outData);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [23:0] d);
    int w;
    inValid = 1'b1;
    inData  = d;
    #1;
    w = 0;
    while (inReady !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) checkOutput("acceptTimeout", 0, 1);
    tick();
  endtask

  task automatic lookupA(input logic [23:0] d, output logic [7:0] o);
    outReady = 1'b1;
    applyStimulus(d);
    inValid = 1'b0;
    tick();
    checkOutput("lookupValidA", {31'd0, outValid}, 1);
    o = outData;
  endtask

  task automatic lookupB(input logic [17:0] d, output logic [5:0] o);
    int w;
    bInValid = 1'b1;
    bInData  = d;
    #1;
    w = 0;
    while (bInReady !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) checkOutput("acceptTimeoutB", 0, 1);
    tick();
    bInValid = 1'b0;
    tick();
    checkOutput("lookupValidB", {31'd0, bOutValid}, 1);
    o = bOutData;
  endtask

  task automatic cfgWrite(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d);
    int w;
    cfgValid  = 1'b1;
    cfgNeuron = n;
    cfgAddr   = a;
    cfgData   = d;
    #1;
    w = 0;
    while (cfgReady !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) checkOutput("cfgTimeout", 0, 1);
    tick();
  endtask

  task automatic cfgWriteB(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d);
    int w;
    bCfgValid  = 1'b1;
    bCfgNeuron = n;
    bCfgAddr   = a;
    bCfgData   = d;
    #1;
    w = 0;
    while (bCfgReady !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) checkOutput("cfgTimeoutB", 0, 1);
    tick();
  endtask

  initial begin
    int          cyc;
    logic [7:0]  resA;
    logic [5:0]  resB;

    checks = 0;
    errors = 0;
    beats   = '{24'h000020, 24'h000005, 24'h000040, 24'h000060, 24'h000085, 24'h0000C0};
    beatExp = '{8'h02, 8'h03, 8'h04, 8'h06, 8'h0B, 8'h0C};

    rst_n = 1'b1;
    inValid = 1'b1; inData = 24'hFA5041; outReady = 1'b1;
    cfgValid = 1'b0; cfgNeuron = '0; cfgAddr = '0; cfgData = '0;
    bInValid = 1'b0; bInData = '0; bOutReady = 1'b1;
    bCfgValid = 1'b0; bCfgNeuron = '0; bCfgAddr = '0; bCfgData = '0;

    // T1: reset values, INIT duration, zeroed tables
    #3 rst_n = 1'b0;
    #5;
    checkOutput("rstOutValid", {31'd0, outValid}, 0);
    checkOutput("rstOutData", {24'd0, outData}, 0);
    checkOutput("rstInReady", {31'd0, inReady}, 0);
    checkOutput("rstCfgReady", {31'd0, cfgReady}, 0);
    checkOutput("rstCfgErr", {31'd0, cfgErr}, 0);
    checkOutput("rstBusy", {31'd0, busy}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (inReady !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checkOutput("initCycles", cyc, 64);
    checkOutput("runBusy", {31'd0, busy}, 0);
    tick();
    inValid = 1'b0;
    checkOutput("latencyNotYet", {31'd0, outValid}, 0);
    tick();
    checkOutput("zeroLookupValid", {31'd0, outValid}, 1);
    checkOutput("zeroLookupData", {24'd0, outData}, 0);
    tick();
    checkOutput("validDropsIdle", {31'd0, outValid}, 0);

    // T2: load tables, back-to-back lookups
    cfgValid = 1'b1; cfgNeuron = 2'd0; cfgAddr = 6'h20; cfgData = 2'b10;
    inValid = 1'b1;
    #1;
    checkOutput("cfgBlocksInReady", {31'd0, inReady}, 0);
    inValid = 1'b0;
    cfgWrite(2'd0, 6'h20, 2'b10);
    cfgWrite(2'd0, 6'h05, 2'b11);
    cfgWrite(2'd1, 6'h01, 2'b01);
    cfgWrite(2'd1, 6'h02, 2'b10);
    cfgWrite(2'd1, 6'h03, 2'b11);
    cfgValid = 1'b0;
    tick();
    checkOutput("cfgBackToRun", {31'd0, busy}, 0);
    inValid = 1'b1; inData = beats[0];
    #1;
    checkOutput("t2InReady", {31'd0, inReady}, 1);
    tick();
    checkOutput("t2Latency", {31'd0, outValid}, 0);
    inData = beats[1];
    tick();
    checkOutput("t2Beat0Valid", {31'd0, outValid}, 1);
    checkOutput("t2Beat0", {24'd0, outData}, 8'h02);
    inData = 24'h000000;
    tick();
    checkOutput("t2Beat1", {24'd0, outData}, 8'h03);
    inValid = 1'b0;
    tick();
    checkOutput("t2Beat2", {24'd0, outData}, 8'h00);
    checkOutput("t2Beat2Valid", {31'd0, outValid}, 1);
    tick();
    checkOutput("t2Idle", {31'd0, outValid}, 0);

    // T3: 5-cycle downstream stall while streaming
    rxQ.delete();
    outReady = 1'b0; inValid = 1'b1; inData = beats[0];
    tick();
    inData = beats[1];
    #1;
    checkOutput("t3SecondReady", {31'd0, inReady}, 1);
    tick();
    inData = beats[2];
    #1;
    checkOutput("t3StallInReady", {31'd0, inReady}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3StableData", {24'd0, outData}, 8'h02);
      checkOutput("t3StallHold", {31'd0, inReady}, 0);
    end
    outReady = 1'b1;
    for (int k = 2; k < 6; k++) applyStimulus(beats[k]);
    inValid = 1'b0;
    repeat (6) tick();
    checkOutput("t3RxCount", rxQ.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < rxQ.size()) checkOutput("t3RxBeat", {24'd0, rxQ[k]}, {24'd0, beatExp[k]});
    end

    // T4: config request with two beats stalled in the pipe
    rxQ.delete();
    outReady = 1'b0; inValid = 1'b1; inData = beats[0];
    tick();
    inData = beats[1];
    tick();
    inValid = 1'b0;
    cfgValid = 1'b1; cfgNeuron = 2'd0; cfgAddr = 6'h20; cfgData = 2'b01;
    #1;
    checkOutput("t4InReady", {31'd0, inReady}, 0);
    tick();
    checkOutput("t4DrainBusy", {31'd0, busy}, 1);
    checkOutput("t4DrainCfgReady", {31'd0, cfgReady}, 0);
    tick();
    checkOutput("t4DrainHold", {31'd0, cfgReady}, 0);
    checkOutput("t4DrainData", {24'd0, outData}, 8'h02);
    outReady = 1'b1;
    tick();
    checkOutput("t4OneLeft", {31'd0, cfgReady}, 0);
    tick();
    checkOutput("t4S2Empty", {31'd0, outValid}, 0);
    checkOutput("t4StillDrain", {31'd0, cfgReady}, 0);
    tick();
    checkOutput("t4InCfg", {31'd0, cfgReady}, 1);
    tick();
    cfgValid = 1'b0;
    tick();
    checkOutput("t4BackToRun", {31'd0, busy}, 0);
    checkOutput("t4RxCount", rxQ.size(), 2);
    if (rxQ.size() == 2) begin
      checkOutput("t4Rx0", {24'd0, rxQ[0]}, 8'h02);
      checkOutput("t4Rx1", {24'd0, rxQ[1]}, 8'h03);
    end
    lookupA(beats[0], resA);
    checkOutput("t4NewValue", {24'd0, resA}, 8'h01);

    // T5: out-of-range neuron on the 3-neuron layer
    cfgWriteB(2'd3, 6'h20, 2'b11);
    checkOutput("t5ErrPulse", {31'd0, bCfgErr}, 1);
    bCfgValid = 1'b0;
    tick();
    checkOutput("t5ErrCleared", {31'd0, bCfgErr}, 0);
    lookupB(18'h20820, resB);
    checkOutput("t5NoWrite", {26'd0, resB}, 0);
    cfgWriteB(2'd2, 6'h20, 2'b11);
    checkOutput("t5NoErr", {31'd0, bCfgErr}, 0);
    bCfgValid = 1'b0;
    tick();
    lookupB(18'h20820, resB);
    checkOutput("t5InRangeWrite", {26'd0, resB}, 6'h30);

    // T6: reset with layer B in CFG and layer A streaming
    bCfgValid = 1'b1; bCfgNeuron = 2'd0; bCfgAddr = 6'h05; bCfgData = 2'b01;
    #1;
    cyc = 0;
    while (bCfgReady !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    if (cyc >= 100) checkOutput("t6CfgTimeout", 0, 1);
    outReady = 1'b1; inValid = 1'b1; inData = beats[3];
    tick();
    inData = beats[4];
    tick();
    checkOutput("t6PreRstValid", {31'd0, outValid}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6RstOutValid", {31'd0, outValid}, 0);
    checkOutput("t6RstOutData", {24'd0, outData}, 0);
    checkOutput("t6RstBusy", {31'd0, busy}, 1);
    checkOutput("t6RstCfgReadyB", {31'd0, bCfgReady}, 0);
    checkOutput("t6RstBusyB", {31'd0, bBusy}, 1);
    inValid = 1'b0;
    bCfgValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checkOutput("t6InitCycles", cyc, 64);
    lookupA(beats[3], resA);
    checkOutput("t6ClearedA0", {24'd0, resA}, 0);
    lookupA(beats[4], resA);
    checkOutput("t6ClearedA1", {24'd0, resA}, 0);
    lookupB(18'h20820, resB);
    checkOutput("t6ClearedB", {26'd0, resB}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
